lcd_word_printer: RTL
=====================

# lcd_word_printer

Converts an 18-bit processor bus word into five uppercase hex ASCII characters and streams them, most significant digit first, to the LCD driver. Each character is sent with a valid/ready handshake, and a programmable gap is inserted between characters to satisfy LCD write timing. It sits between the datapath (memory output / ALU bus) and the LCD driver. It replaces raw-word feeding, so the display shows readable register and memory contents. The control block starts a print and waits for `done`.

## Interface

**Parameters**
- `DATA_W`, 18: width of the word to print. The digit count is fixed at `ceil(DATA_W/4)` = 5.
- `CHAR_GAP`, 4: idle cycles inserted after each accepted character. 0 means back-to-back.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a print. Sampled only in IDLE.
- `word`, in, DATA_W: value to print. Latched on an accepted `start`.
- `line`, in, 1: target LCD line (0 = line 1, 1 = line 2). Latched together with `word`.
- `busy`, out, 1: high from the cycle after an accepted `start` through the DONE state.
- `done`, out, 1: one-cycle pulse after the last character is accepted.
- `set_line`, out, 1: one-cycle pulse telling the LCD driver to move the cursor.
- `line_out`, out, 1: latched line. Valid while `set_line` is high and held until the next print.
- `char_out`, out, 8: ASCII character.
- `char_valid`, out, 1: `char_out` is valid.
- `char_ready`, in, 1: the LCD driver accepts the character this cycle.

## Operation

**States:** IDLE, SETLN, EMIT, GAP, DONE.

**Transitions**
- IDLE→SETLN when `start`=1. On that edge, latch `word` and `line`, and set the digit index to 4.
- SETLN→EMIT unconditionally. `set_line`=1 for exactly this state.
- In EMIT, `char_valid`=1 and `char_out` = ASCII of the current digit.
- EMIT with `char_ready`=0: stay. `char_out` and `char_valid` hold stable.
- EMIT with `char_ready`=1:
  - If the index is 0, go to DONE.
  - Otherwise decrement the index, then go to GAP if `CHAR_GAP`>0, else stay in EMIT with the next digit.
- In GAP, the counter loads `CHAR_GAP`-1 on entry and decrements. Go to EMIT when it reaches 0. `char_valid`=0.
- DONE→IDLE unconditionally. `done`=1 for this state only.

**Digit extraction and encoding**
- Digit index `i` selects `word_q[4i+3:4i]`, zero-extended above bit 17. Digit 4 is therefore `{2'b00, word_q[17:16]}`.
- Nibble 0–9 maps to 0x30+n. Nibble A–F maps to 0x37+n (0x41–0x46).

**Boundary behaviour**
- `start` while busy is ignored and is not queued.
- Changes to `word` or `line` after the latch do not affect the output.
- `char_ready` while `char_valid`=0 is ignored.
- A `start` in the DONE cycle is ignored. A new print can begin from IDLE on the following cycle.
- Reset at any time, including mid-EMIT with `char_valid` high, returns to IDLE immediately (asynchronously). Any partial print is abandoned and no `done` is generated.

## Timing

**Reset values:**
- `busy`=0, `done`=0, `set_line`=0, `line_out`=0, `char_valid`=0.
- `char_out`=8'h00.
- Internal state = IDLE, index = 0, gap counter = 0.

**Latency, with `start` accepted at edge 0 and `char_ready` tied high:**
- `set_line` is high in cycle 1.
- Character k (k = 0..4) is valid in cycle 2 + k·(`CHAR_GAP`+1).
- `done` is high in cycle 3 + 4·(`CHAR_GAP`+1).
- Total print time: 7 cycles at `CHAR_GAP`=0, 23 cycles at `CHAR_GAP`=4.

**Backpressure:** each cycle of `char_ready`=0 during EMIT adds exactly one cycle.

All outputs are registered or decoded from registered state only. There is no combinational path from `char_ready` to `char_out`.

## Structure

**Shared package (`lcd_pkg`):**
- State encoding.
- ASCII constants `ASCII_0`=8'h30 and `ASCII_A_OFF`=8'h37.
- `HEX_DIGITS`=5.

**Sub-module `hex_to_ascii`:** combinational, 4-bit nibble in, 8-bit ASCII out. It is reused later by other display formatters.

**Top of this block:** FSM, word/line latch, digit index counter, and gap counter, in one module.

## Test plan

1. **Reset values.** Hold `reset`=0 and toggle `start` → all outputs stay at their reset values. After release, no activity occurs until `start`.
2. **Basic print.** `word`=18'h3ABCD, `line`=1, `char_ready`=1, `CHAR_GAP`=0 →
   - `set_line`=1 with `line_out`=1 in cycle 1.
   - `char_out` = 0x33, 0x41, 0x42, 0x43, 0x44 in cycles 2–6.
   - `done` in cycle 7, and `busy` drops in cycle 8.
3. **Boundary words.** 18'h00000 prints 0x30 ×5. 18'h3FFFF prints 0x33 followed by 0x46 ×4.
4. **Backpressure.** `CHAR_GAP`=0; hold `char_ready`=0 for 3 cycles when the second digit is presented → `char_out` is held at 0x41 with `char_valid` high. No digit is skipped or duplicated, and `done` moves from cycle 7 to cycle 10.
5. **Gap timing and ignored inputs.** `CHAR_GAP`=4 → `char_valid` is high only in cycles 2, 7, 12, 17, 22, and `done` is in cycle 23. A `start` with a new `word` in cycle 5 is ignored and the output digits are unchanged.
6. **Reset mid-print.** Assert reset while the third digit is valid → `char_valid` and `busy` drop asynchronously and no `done` is produced. The next `start` prints all five digits from digit 4.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text formatters: FSM state encoding,
// ASCII constants and a nibble-select helper.
// No ports; imported by lcd_word_printer and hex_to_ascii.
package lcd_pkg;

    // Number of hex digits printed for one bus word.
    localparam int HEX_DIGITS = 5;

    // '0' for nibbles 0-9; 'A'-10 for nibbles A-F.
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFF = 8'h37;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETLN,
        ST_EMIT,
        ST_GAP,
        ST_DONE
    } state_t;

    // Returns hex digit 'idx' (0 = least significant) of a word that has
    // already been zero-extended to a whole number of nibbles.
    function automatic logic [3:0] nibble_at(input logic [HEX_DIGITS*4-1:0] w,
                                             input logic [2:0]              idx);
        return w[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase hex ASCII encoder ('0'-'9', 'A'-'F').
// Ports: nibble (4-bit value in), ascii (8-bit character out).
// Zero latency, no handshake; shared by the display formatters.
module hex_to_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_0 + {4'h0, nibble};
        if (nibble > 4'd9) begin
            ascii = ASCII_A_OFF + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/lcd_word_printer.sv
// Prints a bus word as five hex ASCII characters (MS digit first) to the LCD
// driver: one set_line pulse, then each character with valid/ready, a
// CHAR_GAP idle gap after every accepted character, then a done pulse.
// Ports: clk/reset (async active-low), start/word/line request, busy/done
// status, set_line/line_out cursor control, char_out/char_valid/char_ready.
// Latency: 7 cycles at CHAR_GAP=0; each stalled EMIT cycle adds one cycle.
module lcd_word_printer
    import lcd_pkg::*;
#(
    parameter int DATA_W   = 18,
    parameter int CHAR_GAP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] word,
    input  logic              line,
    output logic              busy,
    output logic              done,
    output logic              set_line,
    output logic              line_out,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready
);

    localparam int PAD_W = HEX_DIGITS * 4;
    localparam int GAP_W = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
    localparam logic [2:0] TOP_DIGIT = 3'(HEX_DIGITS - 1);

    state_t             state;
    logic [DATA_W-1:0]  word_q;
    logic [2:0]         idx;
    logic [GAP_W-1:0]   gap_cnt;

    logic [PAD_W-1:0]   word_in_pad;
    logic [PAD_W-1:0]   word_q_pad;
    logic [2:0]         idx_next;
    logic [3:0]         nib;
    logic [7:0]         nib_ascii;

    assign word_in_pad = {{(PAD_W - DATA_W){1'b0}}, word};
    assign word_q_pad  = {{(PAD_W - DATA_W){1'b0}}, word_q};
    assign idx_next    = (idx == 3'd0) ? 3'd0 : idx - 3'd1;

    // char_out is registered, so the encoder looks one digit ahead: in IDLE it
    // prepares the top digit of the incoming word, afterwards the digit that
    // follows the one currently on the bus. char_ready never reaches char_out
    // combinationally.
    always_comb begin
        nib = nibble_at(word_q_pad, idx_next);
        if (state == ST_IDLE) begin
            nib = nibble_at(word_in_pad, TOP_DIGIT);
        end
    end

    hex_to_ascii u_hex_to_ascii (
        .nibble (nib),
        .ascii  (nib_ascii)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            idx        <= 3'd0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            set_line   <= 1'b0;
            line_out   <= 1'b0;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_q   <= word;
                        line_out <= line;
                        idx      <= TOP_DIGIT;
                        char_out <= nib_ascii;
                        busy     <= 1'b1;
                        set_line <= 1'b1;
                        state    <= ST_SETLN;
                    end
                end

                ST_SETLN: begin
                    set_line   <= 1'b0;
                    char_valid <= 1'b1;
                    state      <= ST_EMIT;
                end

                ST_EMIT: begin
                    if (char_ready) begin
                        if (idx == 3'd0) begin
                            char_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx      <= idx_next;
                            char_out <= nib_ascii;
                            // With no gap the next digit follows back-to-back
                            // and char_valid simply stays high.
                            if (CHAR_GAP > 0) begin
                                char_valid <= 1'b0;
                                gap_cnt    <= GAP_W'(CHAR_GAP - 1);
                                state      <= ST_GAP;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        char_valid <= 1'b1;
                        state      <= ST_EMIT;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
